// File: rtl/sha3_hps_ctrl.sv
// sha3_hps_ctrl
//
// Avalon-MM slave that sequences the SHA3-256 core for the HPS. Software
// fills a one-rate-block message buffer, writes a start command, and the
// controller streams the buffered words to the core, waits for completion
// (bounded by a timeout), and captures the 256-bit digest into readable
// registers. A sticky done flag and an interrupt report completion.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   address, chipselect, write_n, writedata, readdata
//                       Avalon-MM slave, zero-wait-state combinational reads
//   core_start          one-cycle pulse that starts the core
//   core_word, core_word_valid, core_word_ready
//                       message word stream to the core
//   core_done, core_digest
//                       completion pulse and digest from the core
//   done_flag, irq      sticky completion status and gated interrupt
//
// Register map (word addresses):
//   0 CTRL      W   bit0 start, bit1 abort
//   1 STATUS    R   bit0 busy, bit1 done, bit2 timeout, bit3 start_err,
//                   bits[5:4] state; W1C on bits 1..3
//   2 MSG_DATA  W   append word at wr_ptr
//   3 MSG_COUNT R   wr_ptr
//   4 IRQ_EN    RW  bit0
//   8..15 DIGEST R  digest words 0..7
//
// State | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for software; buffer may be loaded
// FEED  | streaming buffer words to the core, one per accepted cycle
// WAIT  | all words sent, waiting for core_done or timeout

module sha3_hps_ctrl #(
  parameter int MSG_WORDS      = 34,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   address,
  input  logic         chipselect,
  input  logic         write_n,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  output logic         core_start,
  output logic [31:0]  core_word,
  output logic         core_word_valid,
  input  logic         core_word_ready,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         done_flag,
  output logic         irq
);

  localparam int PTR_W = $clog2(MSG_WORDS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(MSG_WORDS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MSG_WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FEED = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TO_W-1:0]  to_cnt;
  logic             done;
  logic             timeout;
  logic             start_err;
  logic             irq_en;
  logic [31:0]      msg_buf   [MSG_WORDS];
  logic [31:0]      digest_q  [8];

  logic wr_en;
  logic cmd_start;
  logic cmd_abort;
  logic wr_status;
  logic wr_msg;
  logic wr_irqen;
  logic msg_accept;
  logic start_ok;
  logic start_bad;
  logic set_done;
  logic set_timeout;
  logic busy;

  // Address decode
  assign wr_en     = chipselect & ~write_n;
  assign cmd_start = wr_en && (address == 4'd0) && writedata[0];
  assign cmd_abort = wr_en && (address == 4'd0) && writedata[1];
  assign wr_status = wr_en && (address == 4'd1);
  assign wr_msg    = wr_en && (address == 4'd2);
  assign wr_irqen  = wr_en && (address == 4'd4);

  assign busy = (state != ST_IDLE);

  // Buffer is frozen while a block is in flight and once it is full.
  assign msg_accept = wr_msg && !busy && (wr_ptr != PTR_FULL);

  // Abort in the same write suppresses start entirely.
  assign start_ok  = cmd_start && !cmd_abort && !busy && (wr_ptr == PTR_FULL);
  assign start_bad = cmd_start && !cmd_abort && !busy && (wr_ptr != PTR_FULL);

  // core_done beats the timeout terminal count; abort leaves done untouched.
  assign set_done    = (state == ST_WAIT) && core_done && !cmd_abort;
  assign set_timeout = (state == ST_WAIT) && !core_done && (to_cnt == TO_LAST)
                       && !cmd_abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      to_cnt     <= '0;
      core_start <= 1'b0;
    end else begin
      core_start <= start_ok;
      if (cmd_abort) begin
        state  <= ST_IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        to_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_ok) begin
              state  <= ST_FEED;
              rd_ptr <= '0;
            end
            if (msg_accept) wr_ptr <= wr_ptr + PTR_W'(1);
          end
          ST_FEED: begin
            if (core_word_ready) begin
              if (rd_ptr == PTR_LAST) begin
                state  <= ST_WAIT;
                to_cnt <= '0;
              end else begin
                rd_ptr <= rd_ptr + PTR_W'(1);
              end
            end
          end
          ST_WAIT: begin
            if (core_done || (to_cnt == TO_LAST)) begin
              state  <= ST_IDLE;
              wr_ptr <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Status flags: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      timeout   <= 1'b0;
      start_err <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      done      <= set_done    | (done      & ~(wr_status & writedata[1]));
      timeout   <= set_timeout | (timeout   & ~(wr_status & writedata[2]));
      start_err <= start_bad   | (start_err & ~(wr_status & writedata[3]));
      if (wr_irqen) irq_en <= writedata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) digest_q[i] <= '0;
    end else if (set_done) begin
      for (int i = 0; i < 8; i++) digest_q[i] <= core_digest[i*32 +: 32];
    end
  end

  // Message buffer has no reset: contents survive completion and only
  // wr_ptr rewinds.
  always_ff @(posedge clk) begin
    if (!reset && msg_accept) msg_buf[wr_ptr] <= writedata;
  end

  assign core_word_valid = (state == ST_FEED);
  assign core_word       = core_word_valid ? msg_buf[rd_ptr] : 32'd0;
  assign done_flag       = done;
  assign irq             = done & irq_en;

  always_comb begin
    readdata = 32'd0;
    case (address)
      4'd1:    readdata = {26'd0, state, start_err, timeout, done, busy};
      4'd3:    readdata = 32'(wr_ptr);
      4'd4:    readdata = {31'd0, irq_en};
      default: if (address[3]) readdata = digest_q[address[2:0]];
    endcase
  end

endmodule

// File: tb/tb_sha3_hps_ctrl.sv
module tb_sha3_hps_ctrl;

  localparam int MSG_WORDS = 34;
  localparam int TO_CYC    = 16;

  localparam logic [3:0] P_READ  = 4'd0;
  localparam logic [3:0] P_START = 4'd1;
  localparam logic [3:0] P_VALID = 4'd2;
  localparam logic [3:0] P_WORD  = 4'd3;
  localparam logic [3:0] P_DONE  = 4'd4;
  localparam logic [3:0] P_IRQ   = 4'd5;
  localparam logic [3:0] P_SCNT  = 4'd6;
  localparam logic [3:0] P_XCNT  = 4'd7;

  localparam logic [255:0] DIG_A =
    256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;
  localparam logic [255:0] DIG_B =
    256'h88888888777777776666666655555555444444443333333322222222_11111111;

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] exp;
  } probe_t;

  logic         clk;
  logic         reset;
  logic [3:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         core_start;
  logic [31:0]  core_word;
  logic         core_word_valid;
  logic         core_word_ready;
  logic         core_done;
  logic [255:0] core_digest;
  logic         done_flag;
  logic         irq;

  sha3_hps_ctrl #(.MSG_WORDS(MSG_WORDS), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk             (clk),
    .reset           (reset),
    .address         (address),
    .chipselect      (chipselect),
    .write_n         (write_n),
    .writedata       (writedata),
    .readdata        (readdata),
    .core_start      (core_start),
    .core_word       (core_word),
    .core_word_valid (core_word_valid),
    .core_word_ready (core_word_ready),
    .core_done       (core_done),
    .core_digest     (core_digest),
    .done_flag       (done_flag),
    .irq             (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1);
  end

  logic [31:0] exp_word_q [$];
  probe_t      probe_q    [$];
  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int xfer_cnt = 0;
  int exp_starts = 0;
  int exp_xfers = 0;

  // Monitor / scoreboard: all comparisons happen here, on the falling edge.
  initial begin : monitor
    logic        prev_stall;
    logic [31:0] prev_word;
    logic [31:0] w;
    logic [31:0] act;
    probe_t      p;
    string       nm;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (core_start) start_cnt++;
      if (prev_stall && core_word_valid) begin
        n_vec++;
        if (core_word !== prev_word) begin
          n_err++;
          $display("FAIL stall_hold: core_word=%h required %h", core_word, prev_word);
        end
      end
      if (core_word_valid && core_word_ready) begin
        xfer_cnt++;
        n_vec++;
        if (exp_word_q.size() == 0) begin
          n_err++;
          $display("FAIL word_extra: core_word=%h accepted, required no transfer", core_word);
        end else begin
          w = exp_word_q.pop_front();
          if (core_word !== w) begin
            n_err++;
            $display("FAIL word_order: core_word=%h required %h", core_word, w);
          end
        end
      end
      prev_stall = core_word_valid && !core_word_ready;
      prev_word  = core_word;
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        case (p.kind)
          P_READ:  begin act = readdata;                nm = "readdata";   end
          P_START: begin act = {31'd0, core_start};     nm = "core_start"; end
          P_VALID: begin act = {31'd0, core_word_valid}; nm = "word_valid"; end
          P_WORD:  begin act = core_word;               nm = "core_word";  end
          P_DONE:  begin act = {31'd0, done_flag};      nm = "done_flag";  end
          P_IRQ:   begin act = {31'd0, irq};            nm = "irq";        end
          P_SCNT:  begin act = 32'(start_cnt);          nm = "start_count"; end
          default: begin act = 32'(xfer_cnt);           nm = "xfer_count"; end
        endcase
        n_vec++;
        if (act !== p.exp) begin
          n_err++;
          if (p.kind == P_READ)
            $display("FAIL %s[addr %0d]: got %h required %h", nm, address, act, p.exp);
          else
            $display("FAIL %s: got %h required %h", nm, act, p.exp);
        end
      end
    end
  end

  task automatic probe(input logic [3:0] kind, input logic [31:0] exp);
    probe_t p;
    p.kind = kind;
    p.exp  = exp;
    probe_q.push_back(p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; address = 4'd0; writedata = 32'd0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    probe(P_READ, e);
    tick();
    chipselect = 1'b0; address = 4'd0;
  endtask

  task automatic load(input int n, input logic [31:0] base, input logic [31:0] step,
                      input bit push);
    for (int i = 0; i < n; i++) begin
      wr(4'd2, base + 32'(i) * step);
      if (push) exp_word_q.push_back(base + 32'(i) * step);
    end
  endtask

  // Core model: accepts the whole block, optionally toggling ready; returns
  // in the first cycle after the final acceptance.
  task automatic feed_core(input bit toggle);
    int acc;
    int cyc;
    acc = 0;
    cyc = 0;
    while (acc < MSG_WORDS && cyc < 400) begin
      core_word_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      @(negedge clk);
      if (core_word_valid && core_word_ready) acc++;
      tick();
      cyc++;
    end
    core_word_ready = 1'b0;
    exp_xfers += MSG_WORDS;
    probe(P_XCNT, 32'(exp_xfers));
  endtask

  initial begin
    reset = 1'b1; address = 4'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; core_word_ready = 1'b0; core_done = 1'b0;
    core_digest = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    probe(P_START, 0); probe(P_VALID, 0); probe(P_WORD, 0);
    probe(P_DONE, 0);  probe(P_IRQ, 0);
    reset = 1'b0;
    rd(4'd1, 32'h0); rd(4'd3, 32'h0); rd(4'd4, 32'h0);
    rd(4'd8, 32'h0); rd(4'd15, 32'h0);

    // Basic hash
    load(MSG_WORDS, 32'd0, 32'd1, 1'b1);
    rd(4'd3, 32'd34);
    wr(4'd4, 32'h1);
    rd(4'd4, 32'h1);
    wr(4'd0, 32'h1);
    exp_starts++;
    probe(P_START, 1); probe(P_VALID, 1); probe(P_WORD, 32'd0);
    feed_core(1'b0);
    probe(P_VALID, 0);
    rd(4'd1, 32'h21);
    probe(P_IRQ, 0);
    repeat (3) tick();
    core_done = 1'b1; core_digest = DIG_A;
    probe(P_IRQ, 0);
    tick();
    core_done = 1'b0;
    probe(P_IRQ, 1); probe(P_DONE, 1);
    rd(4'd1, 32'h2);
    for (int i = 0; i < 8; i++)
      rd(4'(8 + i), ((i % 2) == 0) ? 32'h89abcdef : 32'h01234567);
    rd(4'd3, 32'h0);
    probe(P_SCNT, 32'(exp_starts));

    // Backpressure, overflow write, done set vs W1C race
    load(MSG_WORDS, 32'hA500_0000, 32'd3, 1'b1);
    wr(4'd2, 32'hFFFF_FFFF);
    rd(4'd3, 32'd34);
    wr(4'd0, 32'h1);
    exp_starts++;
    feed_core(1'b1);
    wr(4'd2, 32'hDEAD_BEEF);
    rd(4'd3, 32'd34);
    core_done = 1'b1; core_digest = DIG_B;
    wr(4'd1, 32'h2);
    core_done = 1'b0;
    rd(4'd1, 32'h2);
    rd(4'd8, 32'h1111_1111);
    rd(4'd15, 32'h8888_8888);

    // Short block
    wr(4'd1, 32'h2);
    rd(4'd1, 32'h0);
    load(10, 32'h1000, 32'd1, 1'b0);
    rd(4'd3, 32'd10);
    wr(4'd0, 32'h1);
    probe(P_START, 0); probe(P_VALID, 0);
    rd(4'd1, 32'h8);
    wr(4'd1, 32'h8);
    rd(4'd1, 32'h0);
    rd(4'd3, 32'd10);
    probe(P_SCNT, 32'(exp_starts));
    wr(4'd0, 32'h2);
    rd(4'd3, 32'h0);

    // Timeout: 16 WAIT cycles
    load(MSG_WORDS, 32'd100, 32'd1, 1'b1);
    wr(4'd0, 32'h1);
    exp_starts++;
    feed_core(1'b0);
    repeat (15) tick();
    rd(4'd1, 32'h21);
    rd(4'd1, 32'h4);
    rd(4'd3, 32'h0);
    wr(4'd1, 32'h4);
    rd(4'd1, 32'h0);

    // Abort mid-FEED at word 12
    load(MSG_WORDS, 32'h5555_0000, 32'd1, 1'b1);
    wr(4'd0, 32'h1);
    exp_starts++;
    core_word_ready = 1'b1;
    repeat (12) tick();
    core_word_ready = 1'b0;
    probe(P_VALID, 1); probe(P_WORD, 32'h5555_000C);
    wr(4'd0, 32'h2);
    probe(P_VALID, 0); probe(P_WORD, 32'h0);
    exp_word_q.delete();
    exp_xfers += 12;
    probe(P_XCNT, 32'(exp_xfers));
    rd(4'd1, 32'h0);
    rd(4'd3, 32'h0);

    // Abort and start in the same write
    load(MSG_WORDS, 32'd0, 32'd7, 1'b0);
    wr(4'd0, 32'h3);
    probe(P_START, 0); probe(P_VALID, 0);
    rd(4'd1, 32'h0);
    rd(4'd3, 32'h0);
    probe(P_SCNT, 32'(exp_starts));

    // Completion, then reset in the middle of the next WAIT
    load(MSG_WORDS, 32'd200, 32'd1, 1'b1);
    wr(4'd0, 32'h1);
    exp_starts++;
    feed_core(1'b0);
    core_done = 1'b1; core_digest = DIG_A;
    tick();
    core_done = 1'b0;
    probe(P_DONE, 1); probe(P_IRQ, 1);
    load(MSG_WORDS, 32'd300, 32'd1, 1'b1);
    wr(4'd0, 32'h1);
    exp_starts++;
    feed_core(1'b0);
    wr(4'd0, 32'h1);
    probe(P_START, 0);
    rd(4'd1, 32'h23);
    reset = 1'b1;
    tick();
    probe(P_START, 0); probe(P_VALID, 0); probe(P_WORD, 0);
    probe(P_DONE, 0);  probe(P_IRQ, 0);
    rd(4'd1, 32'h0);
    rd(4'd4, 32'h0);
    rd(4'd8, 32'h0);
    rd(4'd3, 32'h0);
    reset = 1'b0;
    probe(P_SCNT, 32'(exp_starts));

    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
